adder_axil_sequencer: RTL

//  AXI4-Lite master that runs one add/sub job on the svlog_adder_amba slave.

---
 rtl/adder_axil_sequencer.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/adder_axil_sequencer.sv
// AXI4-Lite master running one add/sub job on the adder slave: write r0, r1, ctrl; poll status; read r2.
// Latency ~10 cycles with a zero-wait slave; one AXI transaction outstanding at a time; response held until rsp_ready.
module adder_axil_sequencer #(
  parameter int C_M_AXI_ADDR_WIDTH = 5,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int POLL_GAP           = 4,
  parameter int POLL_LIMIT         = 1024
) (
  input  logic                              m_axi_aclk,
  input  logic                              m_axi_areset,
  input  logic                              cmd_valid,
  output logic                              cmd_ready,
  input  logic                              cmd_op,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     cmd_a,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     cmd_b,
  output logic                              rsp_valid,
  input  logic                              rsp_ready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     rsp_data,
  output logic [1:0]                        rsp_err,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     m_axi_awaddr,
  output logic [2:0]                        m_axi_awprot,
  output logic                              m_axi_awvalid,
  input  logic                              m_axi_awready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     m_axi_wdata,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]   m_axi_wstrb,
  output logic                              m_axi_wvalid,
  input  logic                              m_axi_wready,
  input  logic [1:0]                        m_axi_bresp,
  input  logic                              m_axi_bvalid,
  output logic                              m_axi_bready,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     m_axi_araddr,
  output logic [2:0]                        m_axi_arprot,
  output logic                              m_axi_arvalid,
  input  logic                              m_axi_arready,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     m_axi_rdata,
  input  logic [1:0]                        m_axi_rresp,
  input  logic                              m_axi_rvalid,
  output logic                              m_axi_rready
);
  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam int DW = C_M_AXI_DATA_WIDTH;
  localparam int GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam int PW = $clog2(POLL_LIMIT + 1);
  localparam int DONE_BIT = 31;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_WR_A      = 3'd1;
  localparam logic [2:0] S_WR_B      = 3'd2;
  localparam logic [2:0] S_WR_CTRL   = 3'd3;
  localparam logic [2:0] S_RD_STAT   = 3'd4;
  localparam logic [2:0] S_POLL_WAIT = 3'd5;
  localparam logic [2:0] S_RD_RES    = 3'd6;
  localparam logic [2:0] S_RESP      = 3'd7;

  localparam logic [AW-1:0] ADDR_R0   = AW'(8'h00);
  localparam logic [AW-1:0] ADDR_R1   = AW'(8'h04);
  localparam logic [AW-1:0] ADDR_R2   = AW'(8'h08);
  localparam logic [AW-1:0] ADDR_CTRL = AW'(8'h0C);

  localparam logic [1:0] ERR_OK   = 2'b00;
  localparam logic [1:0] ERR_RESP = 2'b01;
  localparam logic [1:0] ERR_TOUT = 2'b10;

  logic [2:0]    r_state;
  logic [DW-1:0] r_b;
  logic          r_op;
  logic [PW-1:0] r_poll_cnt;
  logic [GW-1:0] r_gap_cnt;
  logic [AW-1:0] r_awaddr;
  logic [DW-1:0] r_wdata;
  logic          r_awvalid;
  logic          r_wvalid;
  logic          r_bready;
  logic [AW-1:0] r_araddr;
  logic          r_arvalid;
  logic          r_rready;
  logic          r_rsp_valid;
  logic [DW-1:0] r_rsp_data;
  logic [1:0]    r_rsp_err;
  logic [PW-1:0] w_poll_next;

  assign w_poll_next   = r_poll_cnt + PW'(1);
  assign cmd_ready     = (r_state == S_IDLE);
  assign rsp_valid     = r_rsp_valid;
  assign rsp_data      = r_rsp_data;
  assign rsp_err       = r_rsp_err;
  assign m_axi_awaddr  = r_awaddr;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_awvalid = r_awvalid;
  assign m_axi_wdata   = r_wdata;
  assign m_axi_wstrb   = '1;
  assign m_axi_wvalid  = r_wvalid;
  assign m_axi_bready  = r_bready;
  assign m_axi_araddr  = r_araddr;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_arvalid = r_arvalid;
  assign m_axi_rready  = r_rready;

  always_ff @(posedge m_axi_aclk or posedge m_axi_areset) begin
    if (m_axi_areset) begin
      r_state     <= S_IDLE;
      r_b         <= '0;
      r_op        <= 1'b0;
      r_poll_cnt  <= '0;
      r_gap_cnt   <= '0;
      r_awaddr    <= '0;
      r_wdata     <= '0;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_bready    <= 1'b0;
      r_araddr    <= '0;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_err   <= ERR_OK;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_b        <= cmd_b;
            r_op       <= cmd_op;
            r_poll_cnt <= '0;
            r_awaddr   <= ADDR_R0;
            r_wdata    <= cmd_a;
            r_awvalid  <= 1'b1;
            r_wvalid   <= 1'b1;
            r_bready   <= 1'b1;
            r_state    <= S_WR_A;
          end
        end
        S_WR_A, S_WR_B, S_WR_CTRL: begin
          if (r_awvalid && m_axi_awready) r_awvalid <= 1'b0;
          if (r_wvalid && m_axi_wready)   r_wvalid  <= 1'b0;
          if (r_bready && m_axi_bvalid) begin
            r_bready <= 1'b0;
            if (m_axi_bresp != 2'b00) begin
              r_rsp_err   <= ERR_RESP;
              r_rsp_data  <= '0;
              r_rsp_valid <= 1'b1;
              r_state     <= S_RESP;
            end else if (r_state == S_WR_A) begin
              r_awaddr  <= ADDR_R1;
              r_wdata   <= r_b;
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_bready  <= 1'b1;
              r_state   <= S_WR_B;
            end else if (r_state == S_WR_B) begin
              r_awaddr  <= ADDR_CTRL;
              r_wdata   <= {{(DW-2){1'b0}}, r_op, 1'b1};
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_bready  <= 1'b1;
              r_state   <= S_WR_CTRL;
            end else begin
              r_araddr  <= ADDR_CTRL;
              r_arvalid <= 1'b1;
              r_rready  <= 1'b1;
              r_state   <= S_RD_STAT;
            end
          end
        end
        S_RD_STAT, S_RD_RES: begin
          if (r_arvalid && m_axi_arready) r_arvalid <= 1'b0;
          if (r_rready && m_axi_rvalid) begin
            r_rready <= 1'b0;
            if (m_axi_rresp != 2'b00) begin
              r_rsp_err   <= ERR_RESP;
              r_rsp_data  <= '0;
              r_rsp_valid <= 1'b1;
              r_state     <= S_RESP;
            end else if (r_state == S_RD_RES) begin
              r_rsp_err   <= ERR_OK;
              r_rsp_data  <= m_axi_rdata;
              r_rsp_valid <= 1'b1;
              r_state     <= S_RESP;
            end else if (m_axi_rdata[DONE_BIT]) begin
              r_araddr  <= ADDR_R2;
              r_arvalid <= 1'b1;
              r_rready  <= 1'b1;
              r_state   <= S_RD_RES;
            end else begin
              r_poll_cnt <= w_poll_next;
              if (w_poll_next == PW'(POLL_LIMIT)) begin
                r_rsp_err   <= ERR_TOUT;
                r_rsp_data  <= '0;
                r_rsp_valid <= 1'b1;
                r_state     <= S_RESP;
              end else if (POLL_GAP == 0) begin
                r_arvalid <= 1'b1;
                r_rready  <= 1'b1;
              end else begin
                r_gap_cnt <= '0;
                r_state   <= S_POLL_WAIT;
              end
            end
          end
        end
        S_POLL_WAIT: begin
          // r_araddr still points at ctrl/status from the previous poll
          if (r_gap_cnt == GW'(POLL_GAP - 1)) begin
            r_arvalid <= 1'b1;
            r_rready  <= 1'b1;
            r_state   <= S_RD_STAT;
          end else begin
            r_gap_cnt <= r_gap_cnt + GW'(1);
          end
        end
        default: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
      endcase
    end
  end
endmodule
